// File: rtl/eccop_amm_arb.sv
// rtl/eccop_amm_arb.sv - two-master Avalon-MM round-robin arbiter, optional m1 lock under ECCOP_ARB_LOCK_EN
module eccop_amm_arb #(
   parameter int aw       = 32,
   parameter int dw       = 4,
   parameter int MAX_LOCK = 4
) (
   input  logic            clk,
   input  logic            sreset_n,
   input  logic [aw-1:0]   m0_address,
   input  logic [dw-1:0]   m0_byteenable,
   input  logic [8*dw-1:0] m0_writedata,
   input  logic            m0_write,
   input  logic            m0_read,
   output logic [8*dw-1:0] m0_readdata,
   output logic            m0_waitrequest,
   input  logic [aw-1:0]   m1_address,
   input  logic [dw-1:0]   m1_byteenable,
   input  logic [8*dw-1:0] m1_writedata,
   input  logic            m1_write,
   input  logic            m1_read,
   output logic [8*dw-1:0] m1_readdata,
   output logic            m1_waitrequest,
`ifdef ECCOP_ARB_LOCK_EN
   input  logic            m1_lock,
`endif
   output logic [aw-1:0]   out_address,
   output logic [dw-1:0]   out_byteenable,
   output logic [8*dw-1:0] out_writedata,
   output logic            out_write,
   output logic            out_read,
   input  logic [8*dw-1:0] out_readdata,
   input  logic            out_waitrequest
);

`ifdef ECCOP_ARB_LOCK_EN
   typedef enum logic [1:0] {s_idle = 2'd0, s_busy = 2'd1, s_hold = 2'd2} state_t;
   localparam int LW = $clog2(MAX_LOCK + 1);
   logic [LW-1:0] lock_cnt, lock_cnt_n;
`else
   typedef enum logic {s_idle = 1'b0, s_busy = 1'b1} state_t;
`endif

   // A lock limit of zero would never let m1 complete a locked sequence
   if (MAX_LOCK < 1) begin : g_bad_max_lock
      $error("MAX_LOCK must be at least 1");
   end

   state_t state, state_n;
   logic   gnt, gnt_n;
   logic   last_gnt, last_gnt_n;
   logic   req_0, req_1, sel_req;

   assign req_0   = m0_read | m0_write;
   assign req_1   = m1_read | m1_write;
   assign sel_req = gnt ? req_1 : req_0;

   // Read data is broadcast; only the granted master's completion cycle qualifies it
   assign m0_readdata = out_readdata;
   assign m1_readdata = out_readdata;

   // State, grant and fairness registers
   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         state    <= s_idle;
         gnt      <= 1'b0;
         last_gnt <= 1'b1;
`ifdef ECCOP_ARB_LOCK_EN
         lock_cnt <= '0;
`endif
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         last_gnt <= last_gnt_n;
`ifdef ECCOP_ARB_LOCK_EN
         lock_cnt <= lock_cnt_n;
`endif
      end
   end

   // Next-state: arbitrate in idle, wait for completion in busy, keep m1 in hold
   always_comb begin
      state_n    = state;
      gnt_n      = gnt;
      last_gnt_n = last_gnt;
`ifdef ECCOP_ARB_LOCK_EN
      lock_cnt_n = lock_cnt;
`endif
      case (state)
         s_idle: begin
            if (req_0 | req_1) begin
               gnt_n   = (req_0 & req_1) ? ~last_gnt : req_1;
               state_n = s_busy;
            end
         end
         s_busy: begin
            if (!sel_req) begin
               // granted master abandoned its request: no completion, fairness untouched
               state_n = s_idle;
            end else if (!out_waitrequest) begin
               last_gnt_n = gnt;
               state_n    = s_idle;
`ifdef ECCOP_ARB_LOCK_EN
               lock_cnt_n = '0;
               if (gnt && m1_lock && (int'(lock_cnt) + 1 < MAX_LOCK)) begin
                  lock_cnt_n = lock_cnt + 1'b1;
                  state_n    = s_hold;
               end
`endif
            end
         end
`ifdef ECCOP_ARB_LOCK_EN
         s_hold: begin
            if (req_1) begin
               gnt_n   = 1'b1;
               state_n = s_busy;
            end else if (!m1_lock) begin
               lock_cnt_n = '0;
               state_n    = s_idle;
            end
         end
`endif
         default: state_n = s_idle;
      endcase
   end

   // Output mux: only the granted master reaches the interconnect, and only while busy
   always_comb begin
      out_address    = '0;
      out_byteenable = '0;
      out_writedata  = '0;
      out_write      = 1'b0;
      out_read       = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      if (state == s_busy) begin
         if (gnt) begin
            out_address    = m1_address;
            out_byteenable = m1_byteenable;
            out_writedata  = m1_writedata;
            out_write      = m1_write;
            out_read       = m1_read;
            m1_waitrequest = out_waitrequest;
         end else begin
            out_address    = m0_address;
            out_byteenable = m0_byteenable;
            out_writedata  = m0_writedata;
            out_write      = m0_write;
            out_read       = m0_read;
            m0_waitrequest = out_waitrequest;
         end
      end
   end

endmodule

// File: tb/tb_eccop_amm_arb.sv
// tb/tb_eccop_amm_arb.sv - self-checking bench for eccop_amm_arb
`timescale 1ns/1ps
module tb_eccop_amm_arb;
   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } cmd_t;
   typedef struct {
      int          mst;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
   } exp_t;
   typedef struct {
      int          mst;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          ws;
      logic [31:0] rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        sreset_n = 1'b0;
   logic [31:0] m0_address = '0, m1_address = '0;
   logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic        m0_write = 1'b0, m0_read = 1'b0, m1_write = 1'b0, m1_read = 1'b0;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] out_address, out_writedata, out_readdata;
   logic [3:0]  out_byteenable;
   logic        out_write, out_read, out_waitrequest;
`ifdef ECCOP_ARB_LOCK_EN
   logic        m1_lock = 1'b0;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ws_lat = 0;
   int   wcnt = 0;
   bit   force_wait = 1'b0;
   bit   drv_en = 1'b0;
   bit   m0_acc, m1_acc;
   cmd_t cmd0_q[$];
   cmd_t cmd1_q[$];
   exp_t sb[$];
   exp_t mon_e;
   int   done_cyc[$];

   always #5 clk = ~clk;

   eccop_amm_arb dut (
      .clk             (clk),
      .sreset_n        (sreset_n),
      .m0_address      (m0_address),
      .m0_byteenable   (m0_byteenable),
      .m0_writedata    (m0_writedata),
      .m0_write        (m0_write),
      .m0_read         (m0_read),
      .m0_readdata     (m0_readdata),
      .m0_waitrequest  (m0_waitrequest),
      .m1_address      (m1_address),
      .m1_byteenable   (m1_byteenable),
      .m1_writedata    (m1_writedata),
      .m1_write        (m1_write),
      .m1_read         (m1_read),
      .m1_readdata     (m1_readdata),
      .m1_waitrequest  (m1_waitrequest),
`ifdef ECCOP_ARB_LOCK_EN
      .m1_lock         (m1_lock),
`endif
      .out_address     (out_address),
      .out_byteenable  (out_byteenable),
      .out_writedata   (out_writedata),
      .out_write       (out_write),
      .out_read        (out_read),
      .out_readdata    (out_readdata),
      .out_waitrequest (out_waitrequest)
   );

   // slave: fixed wait states per transfer, read data derived from address
   assign out_readdata    = {out_address[15:0], out_address[31:16]};
   assign out_waitrequest = force_wait | (wcnt < ws_lat);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!sreset_n || !(out_read | out_write) || !out_waitrequest) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b, expected %0b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard: every completion is compared with the next expected transfer
   always @(negedge clk) begin
      m0_acc = (m0_read | m0_write) && !m0_waitrequest;
      m1_acc = (m1_read | m1_write) && !m1_waitrequest;
      if (sreset_n && (out_read | out_write) && !out_waitrequest) begin
         done_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: completion at 0x%0h, expected none", out_address);
         end else begin
            mon_e = sb.pop_front();
            check32("sb_grant", {30'd0, !m1_waitrequest, !m0_waitrequest}, (mon_e.mst == 1) ? 32'd2 : 32'd1);
            check32("sb_addr", out_address, mon_e.addr);
            check32("sb_rw", {30'd0, out_read, out_write}, {30'd0, mon_e.rd, mon_e.wr});
            check32("sb_be", {28'd0, out_byteenable}, {28'd0, mon_e.be});
            if (mon_e.wr) check32("sb_wdata", out_writedata, mon_e.wdata);
            if (mon_e.rd) check32("sb_rdata", (mon_e.mst == 1) ? m1_readdata : m0_readdata, mon_e.rdata);
         end
      end
   end

   // master 0 driver: holds each command until accepted
   initial begin : drv0
      cmd_t c;
      forever begin
         @(posedge clk); #1;
         if (drv_en && (!(m0_read | m0_write) || m0_acc)) begin
            if (cmd0_q.size() != 0) begin
               c = cmd0_q.pop_front();
               m0_read = c.rd; m0_write = c.wr; m0_address = c.addr;
               m0_writedata = c.data; m0_byteenable = c.be;
            end else begin
               m0_read = 1'b0; m0_write = 1'b0;
            end
         end
      end
   end

   // master 1 driver
   initial begin : drv1
      cmd_t c;
      forever begin
         @(posedge clk); #1;
         if (drv_en && (!(m1_read | m1_write) || m1_acc)) begin
            if (cmd1_q.size() != 0) begin
               c = cmd1_q.pop_front();
               m1_read = c.rd; m1_write = c.wr; m1_address = c.addr;
               m1_writedata = c.data; m1_byteenable = c.be;
            end else begin
               m1_read = 1'b0; m1_write = 1'b0;
            end
         end
      end
   end

   task automatic nb();
      @(negedge clk); #1;
   endtask

   task automatic push_cmd(input int mst, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      cmd_t c;
      c.rd = rd; c.wr = wr; c.addr = a; c.data = d; c.be = be;
      if (mst == 1) cmd1_q.push_back(c);
      else cmd0_q.push_back(c);
   endtask

   task automatic push_exp(input int mst, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, input logic [31:0] rdata);
      exp_t e;
      e.mst = mst; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = d; e.be = be; e.rdata = rdata;
      sb.push_back(e);
   endtask

   task automatic push(input int mst, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      push_cmd(mst, rd, wr, a, d, be);
      push_exp(mst, rd, wr, a, d, be, {a[15:0], a[31:16]});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         nb();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d transfers outstanding, expected 0", name, sb.size());
      end
      sb.delete(); cmd0_q.delete(); cmd1_q.delete();
      repeat (2) nb();
   endtask

   task automatic do_reset();
      drv_en = 1'b0;
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      sreset_n = 1'b0;
      repeat (2) nb();
      sreset_n = 1'b1;
      nb();
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t vecs[6];
      int   t0;

      vecs[0] = '{0, 1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_5A5A, 4'hF, 0, 32'h0};
      vecs[1] = '{1, 1'b1, 1'b0, 32'h0000_2008, 32'h0,         4'hF, 1, 32'h2008_0000};
      vecs[2] = '{0, 1'b1, 1'b0, 32'hCAFE_0010, 32'h0,         4'h3, 3, 32'h0010_CAFE};
      vecs[3] = '{1, 1'b0, 1'b1, 32'h0000_3FFC, 32'h0123_4567, 4'h8, 2, 32'h0};
      vecs[4] = '{1, 1'b1, 1'b1, 32'h1111_2222, 32'hFFFF_0000, 4'hF, 0, 32'h2222_1111};
      vecs[5] = '{0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 0, 32'hFFFC_FFFF};

      // reset dominates requests
      m0_read = 1'b1; m1_write = 1'b1; m0_address = 32'h1234; m1_address = 32'h5678;
      repeat (3) @(posedge clk);
      nb();
      check1("rst_out_read", out_read, 1'b0);
      check1("rst_out_write", out_write, 1'b0);
      check32("rst_out_address", out_address, 32'h0);
      check32("rst_out_wdata_be", {out_writedata[27:0], out_byteenable}, 32'h0);
      check1("rst_m0_wait", m0_waitrequest, 1'b1);
      check1("rst_m1_wait", m1_waitrequest, 1'b1);
      m0_read = 1'b0; m1_write = 1'b0;
      sreset_n = 1'b1;
      nb();

      // m0 write, two wait states
      ws_lat = 2;
      push_exp(0, 1'b0, 1'b1, 32'h0000_4004, 32'hDEAD_BEEF, 4'hF, 32'h0);
      m0_address = 32'h0000_4004; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF; m0_write = 1'b1;
      #1 check1("a_idle_out_write", out_write, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         nb();
         check1("a_out_write", out_write, 1'b1);
         check1("a_m0_wait", m0_waitrequest, k != 3);
         check1("a_m1_wait", m1_waitrequest, 1'b1);
      end
      nb();
      check1("a_after_out_write", out_write, 1'b0);
      check1("a_after_m0_wait", m0_waitrequest, 1'b1);
      m0_write = 1'b0;

      // m0 read returns data in the completion cycle
      ws_lat = 1;
      nb();
      push_exp(0, 1'b1, 1'b0, 32'h5678_1234, 32'h0, 4'hF, 32'h1234_5678);
      m0_address = 32'h5678_1234; m0_read = 1'b1;
      nb();
      check1("b_m0_wait_stall", m0_waitrequest, 1'b1);
      nb();
      check32("b_m0_readdata", m0_readdata, 32'h1234_5678);
      check1("b_m0_wait_done", m0_waitrequest, 1'b0);
      nb();
      check1("b_idle_out_read", out_read, 1'b0);
      m0_read = 1'b0;
      drain("ab");

      // single transfers from the vector table
      drv_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ws_lat = vecs[i].ws;
         t0 = cyc;
         push_cmd(vecs[i].mst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         push_exp(vecs[i].mst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rdata);
         drain("vec");
         check32("vec_latency", done_cyc[$] - t0, vecs[i].ws + 2);
      end

      // both masters continuously from reset: m0,m1,m0,m1 two cycles apart
      do_reset();
      ws_lat = 0;
      done_cyc.delete();
      push(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
      push(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
      push(0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
      push(1, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'hF);
      drv_en = 1'b1;
      drain("rr");
      check32("rr_count", done_cyc.size(), 32'd4);
      for (int i = 1; i < done_cyc.size(); i++)
         check32("rr_spacing", done_cyc[i] - done_cyc[i-1], 32'd2);

      // leave last_gnt at m0, then reset in the middle of an m1 read
      push(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
      drain("pre_rst");
      drv_en = 1'b0;
      force_wait = 1'b1;
      m1_address = 32'h0000_0880; m1_byteenable = 4'hF; m1_read = 1'b1;
      nb();
      check1("r_busy_out_read", out_read, 1'b1);
      check1("r_busy_m1_wait", m1_waitrequest, 1'b1);
      sreset_n = 1'b0;
      nb();
      check1("r_rst_out_read", out_read, 1'b0);
      check1("r_rst_m0_wait", m0_waitrequest, 1'b1);
      check1("r_rst_m1_wait", m1_waitrequest, 1'b1);
      sreset_n = 1'b1;
      m1_read = 1'b0;
      force_wait = 1'b0;
      nb();
      push(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
      push(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
      drv_en = 1'b1;
      drain("post_rst");

      // m0 abandons its write before completion
      drv_en = 1'b0;
      force_wait = 1'b1;
      m0_address = 32'h0000_4010; m0_writedata = 32'h55AA_55AA; m0_byteenable = 4'hF; m0_write = 1'b1;
      nb();
      check1("v_busy_out_write", out_write, 1'b1);
      check1("v_busy_m0_wait", m0_waitrequest, 1'b1);
      m0_write = 1'b0;
      nb();
      check1("v_drop_out_write", out_write, 1'b0);
      check1("v_drop_m0_wait", m0_waitrequest, 1'b1);
      check1("v_drop_m1_wait", m1_waitrequest, 1'b1);
      force_wait = 1'b0;
      nb();
      done_cyc.delete();
      t0 = cyc;
      push(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
      push(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
      drv_en = 1'b1;
      drain("post_viol");
      check32("v_first_latency", done_cyc[0] - t0, 32'd2);

`ifdef ECCOP_ARB_LOCK_EN
      // six locked m1 reads with m0 waiting: m1 x4, m0, m1 x2
      do_reset();
      ws_lat = 0;
      m1_lock = 1'b1;
      for (int i = 0; i < 4; i++) push(1, 1'b1, 1'b0, 32'h0000_1100 + 32'(4 * i), 32'h0, 4'hF);
      push_exp(0, 1'b1, 1'b0, 32'h0000_9000, 32'h0, 4'hF, 32'h9000_0000);
      for (int i = 4; i < 6; i++) push(1, 1'b1, 1'b0, 32'h0000_1100 + 32'(4 * i), 32'h0, 4'hF);
      drv_en = 1'b1;
      nb();
      nb();
      push_cmd(0, 1'b1, 1'b0, 32'h0000_9000, 32'h0, 4'hF);
      drain("lock");
      check1("lock_hold_out_read", out_read, 1'b0);
      m1_lock = 1'b0;
      nb();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
